// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a 2-entry skid buffer, synchronous flush and
// saturating stall/bubble counters. in_ready is decoded from registered state only.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic              acc_in, acc_out;

  assign in_ready   = (state_q != FULL);
  assign out_valid  = (state_q != EMPTY);
  assign occupancy  = state_q;
  assign out_ctrl   = out_valid ? main_ctrl_q : '0;
  assign out_data   = main_data_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

  assign acc_in  = in_valid & in_ready;
  assign acc_out = out_valid & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a hold default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Kill validity and control only; data payloads are left as they were.
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc_in) begin
            state_d     = ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ONE: begin
          if (acc_in && acc_out) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (acc_in) begin
            state_d     = FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (acc_out) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (acc_out) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (!out_valid && out_ready && (bubble_cnt_q != '1))
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
      // NOTE: payload registers are reset as well so out_data and the skid
      // entry read zero after reset rather than X.
      main_data_q  <= '0;
      skid_data_q  <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_ctrl_q  <= skid_ctrl_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register between two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing fixed-width, always-advance stage registers. It carries a control bundle and a data bundle with a valid/ready handshake and a 2-entry skid buffer, so `in_ready` has no combinational path from `out_ready`. It also supports a synchronous flush that converts in-flight beats into bubbles, and exposes saturating stall/bubble performance counters.

## Interface
- `DATA_W`, default 96: data bundle width (e.g. pc_count + RD2 + aluResult).
- `CTRL_W`, default 3: control bundle width (e.g. mem_to_reg, mem_write, reg_write). Forced to zero whenever the stage is empty.
- `CNT_W`, default 16: performance counter width.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `flush` input 1: synchronous kill of all held and incoming beats.
- `cnt_clr` input 1: synchronous clear of both counters.
- `in_valid` input 1: upstream beat present.
- `in_ready` output 1: stage can accept a beat.
- `in_ctrl` input CTRL_W: upstream control bundle.
- `in_data` input DATA_W: upstream data bundle.
- `out_valid` output 1: downstream beat present.
- `out_ready` input 1: downstream accepts.
- `out_ctrl` output CTRL_W: control bundle, zero when `out_valid`=0.
- `out_data` output DATA_W: data bundle.
- `occupancy` output 2: entries held (0..2).
- `stall_cnt` output CNT_W: cycles with `out_valid` & !`out_ready`.
- `bubble_cnt` output CNT_W: cycles with `out_ready` & !`out_valid`.

## Operation
- Storage:
  - main entry (drives `out_*`) and skid entry, each holding ctrl + data.
  - State EMPTY/ONE/FULL is encoded as `occupancy` 0/1/2.
- `in_ready` = (state != FULL), decoded from registered state only. `out_valid` = (state != EMPTY).
- Accept-in = `in_valid` & `in_ready`. Accept-out = `out_valid` & `out_ready`.
- State transitions when `flush`=0:
  - EMPTY: accept-in → ONE, main ← in; else stay.
  - ONE, both accepts: stay ONE, main ← in.
  - ONE, accept-in only: → FULL, skid ← in.
  - ONE, accept-out only: → EMPTY.
  - ONE, neither: hold.
  - FULL, accept-out: → ONE, main ← skid. Accept-in is impossible in FULL.
  - FULL, no accept-out: hold both entries.
- Ordering is strictly FIFO; no beat is duplicated or dropped except by flush.
- `flush`=1 has highest priority:
  - Next state is EMPTY regardless of handshakes.
  - A same-cycle incoming beat is discarded.
  - Data registers are not cleared; only validity and ctrl are.
- `out_ctrl` = main.ctrl when `out_valid`, else 0. A bubble never asserts mem_write or reg_write.
- `out_data` = main.data, held when empty.
- Counters:
  - Sampled on the current cycle's `out_valid`/`out_ready`, including flush cycles.
  - Saturate at 2^CNT_W−1.
  - `cnt_clr` zeroes the counter next cycle; clear takes priority over increment.
- Reset values: state EMPTY, `occupancy`=0, `out_valid`=0, `in_ready`=1, `out_ctrl`=0, `out_data`=0, skid=0, `stall_cnt`=0, `bubble_cnt`=0.

## Timing
- Latency: a beat accepted at edge N appears on `out_*` after edge N (1 cycle) when the stage was EMPTY or draining.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- With `out_ready` low, the stage absorbs exactly 2 beats, then deasserts `in_ready` the cycle after the second accept.
- `out_ready` rising while FULL: the main beat leaves at that edge, skid moves to main, and `in_ready`=1 from the next cycle.
- All state changes occur on rising `clk`. `rst` asserted mid-operation clears the stage immediately, without waiting for `clk`.
- The `flush` effect is visible the cycle after assertion: `out_valid`=0 and `out_ctrl`=0.

## Test plan
- Reset mid-stream:
  - Stimulus: fill to FULL, then assert `rst` between edges.
  - Required: immediately `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_ctrl`=0, counters=0.
- Streaming:
  - Stimulus: send data 1..8 with `in_valid`=1 and `out_ready`=1 throughout.
  - Required: outputs 1..8 in order, 1 cycle after input; `in_ready` never low; `stall_cnt`=0.
- Backpressure:
  - Stimulus: `out_ready`=0, offer beats A, B, C.
  - Required: A and B accepted; `in_ready`=0 with `occupancy`=2; C held upstream; `stall_cnt` increments each cycle.
  - Then raise `out_ready`: outputs A, B, C in order with no loss.
- Flush while FULL:
  - Stimulus: flush with a concurrent `in_valid` beat D.
  - Required: next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0; D never appears at the output.
- Bubbles and counters:
  - Stimulus: idle input with `out_ready`=1 for 5 cycles, then pulse `cnt_clr`.
  - Required: `bubble_cnt`=5, then 0 the cycle after the clear.
  - With CNT_W=4, 20 stall cycles leave `stall_cnt`=15 (saturated).
